// File: rtl/uart_apb_fifo.sv
// uart_apb_fifo: APB UART with TX/RX FIFOs, 16-bit baud divider, optional parity,
// sticky W1C status and registered IRQ. Define UART_LOOPBACK_EN to enable CTRL[5] loopback.
module uart_apb_fifo #(
   parameter int unsigned TX_DEPTH   = 8,
   parameter int unsigned RX_DEPTH   = 8,
   parameter logic [15:0] BAUD_RESET = 16'd26
) (
   input  logic        PCLK,
   input  logic        PRESETN,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [4:0]  PADDR,
   input  logic [15:0] PWDATA,
   output logic [15:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   input  logic        RX,
   output logic        TX,
   output logic        TXRDY,
   output logic        RXRDY,
   output logic        IRQ
);
   localparam int unsigned TAW = $clog2(TX_DEPTH);
   localparam int unsigned RAW = $clog2(RX_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

   logic        xfer, mapped, sel_data, sel_stat, sel_ctrl, sel_baud;
   logic [4:0]  ctrl_q;
   logic [5:0]  ctrl_rd;
   logic [15:0] baud_q, bcnt_q;
   logic [3:0]  sticky_q, sticky_d;
   logic        irq_q, tick, rx_src, tx_q;
   logic        unused_paddr;

   assign xfer     = PSEL & PENABLE;
   assign mapped   = ~PADDR[4];
   assign sel_data = xfer & mapped & (PADDR[3:2] == 2'd0);
   assign sel_stat = xfer & mapped & (PADDR[3:2] == 2'd1);
   assign sel_ctrl = xfer & mapped & (PADDR[3:2] == 2'd2);
   assign sel_baud = xfer & mapped & (PADDR[3:2] == 2'd3);
   assign PREADY   = 1'b1;
   assign PSLVERR  = xfer & ~mapped;
   assign unused_paddr = ^PADDR[1:0];

   // ---------------- TX FIFO ----------------
   logic [7:0]   txm_q [TX_DEPTH];
   logic [TAW:0] txw_q, txr_q;
   logic         tx_empty, tx_full, tx_push, tx_pop;
   state_e       txs_q;
   logic [3:0]   ttc_q;
   logic [2:0]   tbit_q;
   logic [7:0]   tsh_q;
   logic         tpar_q;

   assign tx_empty = (txw_q == txr_q);
   assign tx_full  = (txw_q[TAW] != txr_q[TAW]) && (txw_q[TAW-1:0] == txr_q[TAW-1:0]);
   assign tx_push  = sel_data & PWRITE & ~tx_full;
   // The FSM loads the next byte either from IDLE or straight out of STOP, so frames abut.
   assign tx_pop   = tick & ~tx_empty &
                     ((txs_q == S_IDLE) | ((txs_q == S_STOP) & (ttc_q == 4'hF)));

   always_ff @(posedge PCLK) begin
      if (tx_push) txm_q[txw_q[TAW-1:0]] <= PWDATA[7:0];
   end

   // ---------------- RX FIFO ----------------
   logic [7:0]   rxm_q [RX_DEPTH];
   logic [RAW:0] rxw_q, rxr_q;
   logic         rx_empty, rx_full, rx_push, rx_pop, rx_done;
   state_e       rxs_q;
   logic [3:0]   rtc_q;
   logic [2:0]   rbit_q;
   logic [7:0]   rsh_q;
   logic         rpar_q, rs1_q, rs2_q, rprev_q;

   assign rx_empty = (rxw_q == rxr_q);
   assign rx_full  = (rxw_q[RAW] != rxr_q[RAW]) && (rxw_q[RAW-1:0] == rxr_q[RAW-1:0]);
   assign rx_done  = (rxs_q == S_STOP) & tick & (rtc_q == 4'hF);
   assign rx_pop   = sel_data & ~PWRITE & ~rx_empty;
   assign rx_push  = rx_done & (~rx_full | rx_pop);

   always_ff @(posedge PCLK) begin
      if (rx_push) rxm_q[rxw_q[RAW-1:0]] <= rsh_q;
   end

`ifdef UART_LOOPBACK_EN
   logic loop_q;
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN)                loop_q <= 1'b0;
      else if (sel_ctrl && PWRITE) loop_q <= PWDATA[5];
   end
   assign rx_src  = loop_q ? tx_q : RX;
   assign TX      = loop_q | tx_q;
   assign ctrl_rd = {loop_q, ctrl_q};
`else
   assign rx_src  = RX;
   assign TX      = tx_q;
   assign ctrl_rd = {1'b0, ctrl_q};
`endif

   assign tick  = (bcnt_q == baud_q);
   assign TXRDY = ~tx_full;
   assign RXRDY = ~rx_empty;
   assign IRQ   = irq_q;

   always_comb begin
      sticky_d = sticky_q;
      if (sel_stat && PWRITE) sticky_d = sticky_d & ~PWDATA[6:3];
      sticky_d = sticky_d | {sel_data & PWRITE & tx_full,
                             rx_done & ctrl_q[0] & (rpar_q != ((^rsh_q) ^ ctrl_q[1])),
                             rx_done & ~rs2_q,
                             rx_done & rx_full & ~rx_pop};
   end

   always_comb begin
      PRDATA = '0;
      if (xfer && !PWRITE && mapped) begin
         case (PADDR[3:2])
            2'd0:    PRDATA = rx_empty ? '0 : {8'h00, rxm_q[rxr_q[RAW-1:0]]};
            2'd1:    PRDATA = {9'd0, sticky_q, tx_empty, ~rx_empty, ~tx_full};
            2'd2:    PRDATA = {10'd0, ctrl_rd};
            default: PRDATA = baud_q;
         endcase
      end
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         ctrl_q   <= '0;
         baud_q   <= BAUD_RESET;
         bcnt_q   <= '0;
         sticky_q <= '0;
         irq_q    <= 1'b0;
         txw_q    <= '0;
         txr_q    <= '0;
         rxw_q    <= '0;
         rxr_q    <= '0;
      end else begin
         if (sel_ctrl && PWRITE) ctrl_q <= PWDATA[4:0];
         if (sel_baud && PWRITE) baud_q <= PWDATA;
         if ((sel_baud && PWRITE) || tick) bcnt_q <= '0;
         else                               bcnt_q <= bcnt_q + 16'd1;
         sticky_q <= sticky_d;
         irq_q    <= (ctrl_q[2] & ~rx_empty) | (ctrl_q[3] & tx_empty & (txs_q == S_IDLE)) |
                     (ctrl_q[4] & (|sticky_q));
         if (tx_push) txw_q <= txw_q + (TAW+1)'(1);
         if (tx_pop)  txr_q <= txr_q + (TAW+1)'(1);
         if (rx_push) rxw_q <= rxw_q + (RAW+1)'(1);
         if (rx_pop)  rxr_q <= rxr_q + (RAW+1)'(1);
      end
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         txs_q  <= S_IDLE;
         ttc_q  <= '0;
         tbit_q <= '0;
         tsh_q  <= '0;
         tpar_q <= 1'b0;
         tx_q   <= 1'b1;
      end else if (tick) begin
         if (txs_q == S_IDLE) begin
            if (!tx_empty) begin
               txs_q <= S_START;
               tx_q  <= 1'b0;
               ttc_q <= '0;
               tsh_q <= txm_q[txr_q[TAW-1:0]];
            end
         end else if (ttc_q != 4'hF) begin
            ttc_q <= ttc_q + 4'd1;
         end else begin
            ttc_q <= '0;
            case (txs_q)
               S_START: begin
                  txs_q  <= S_DATA;
                  tx_q   <= tsh_q[0];
                  tbit_q <= '0;
                  tpar_q <= (^tsh_q) ^ ctrl_q[1];
               end
               S_DATA: begin
                  if (tbit_q == 3'd7) begin
                     txs_q <= ctrl_q[0] ? S_PARITY : S_STOP;
                     tx_q  <= ctrl_q[0] ? tpar_q : 1'b1;
                  end else begin
                     tbit_q <= tbit_q + 3'd1;
                     tsh_q  <= tsh_q >> 1;
                     tx_q   <= tsh_q[1];
                  end
               end
               S_PARITY: begin
                  txs_q <= S_STOP;
                  tx_q  <= 1'b1;
               end
               default: begin
                  if (!tx_empty) begin
                     txs_q <= S_START;
                     tx_q  <= 1'b0;
                     tsh_q <= txm_q[txr_q[TAW-1:0]];
                  end else begin
                     txs_q <= S_IDLE;
                  end
               end
            endcase
         end
      end
   end

   // Start is qualified at tick 8; later bits are sampled 16 ticks apart, i.e. at mid-bit.
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         rs1_q   <= 1'b1;
         rs2_q   <= 1'b1;
         rprev_q <= 1'b1;
         rxs_q   <= S_IDLE;
         rtc_q   <= '0;
         rbit_q  <= '0;
         rsh_q   <= '0;
         rpar_q  <= 1'b0;
      end else begin
         rs1_q   <= rx_src;
         rs2_q   <= rs1_q;
         rprev_q <= rs2_q;
         case (rxs_q)
            S_IDLE: begin
               if (rprev_q && !rs2_q) begin
                  rxs_q <= S_START;
                  rtc_q <= '0;
               end
            end
            S_START: begin
               if (tick) begin
                  if (rtc_q == 4'd7) begin
                     rtc_q  <= '0;
                     rbit_q <= '0;
                     rxs_q  <= rs2_q ? S_IDLE : S_DATA;
                  end else begin
                     rtc_q <= rtc_q + 4'd1;
                  end
               end
            end
            default: begin
               if (tick) begin
                  if (rtc_q != 4'hF) begin
                     rtc_q <= rtc_q + 4'd1;
                  end else begin
                     rtc_q <= '0;
                     if (rxs_q == S_DATA) begin
                        rsh_q <= {rs2_q, rsh_q[7:1]};
                        if (rbit_q == 3'd7) rxs_q <= ctrl_q[0] ? S_PARITY : S_STOP;
                        else                rbit_q <= rbit_q + 3'd1;
                     end else if (rxs_q == S_PARITY) begin
                        rpar_q <= rs2_q;
                        rxs_q  <= S_STOP;
                     end else begin
                        rxs_q <= S_IDLE;
                     end
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_apb_fifo.sv
// Directed/randomised bench for uart_apb_fifo: APB access, TX framing, RX reception,
// sticky status, IRQ and reset behaviour, checked against a queue-based reference model.
module tb_uart_apb_fifo;
   localparam logic [4:0] A_DATA = 5'h00, A_STAT = 5'h04, A_CTRL = 5'h08, A_BAUD = 5'h0C;
   localparam int unsigned BIT = 64;

   logic        clk = 1'b0, rst_n = 1'b1;
   logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0, rx = 1'b1;
   logic [4:0]  paddr = '0;
   logic [15:0] pwdata = '0;
   logic [15:0] prdata;
   logic        pready, pslverr, tx, txrdy, rxrdy, irq;

   int unsigned n_assert = 0, n_fail = 0, cyc = 0;
   logic [7:0]  rxq[$];
   logic [7:0]  txb[$];
   bit          e_ovf = 0, e_frm = 0, e_par = 0, e_txovf = 0;
   logic [15:0] rdata;
   logic        err;
   logic [7:0]  d, a;
   int unsigned t0, t1, zeros;

   uart_apb_fifo #(.TX_DEPTH(8), .RX_DEPTH(8), .BAUD_RESET(16'd26)) dut (
      .PCLK(clk), .PRESETN(rst_n), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
      .RX(rx), .TX(tx), .TXRDY(txrdy), .RXRDY(rxrdy), .IRQ(irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] exp_status(input int tx_cnt, input int rx_cnt);
      return {9'd0, e_txovf, e_par, e_frm, e_ovf, tx_cnt == 0, rx_cnt != 0, tx_cnt < 8};
   endfunction

   function automatic logic par_bit(input logic [7:0] v, input bit odd);
      bit ones_odd;
      ones_odd = ($countones(v) % 2) == 1;
      return odd ? !ones_odd : ones_odd;
   endfunction

   task automatic tick1();
      @(posedge clk); #1;
   endtask

   task automatic wait_until(input int unsigned target);
      while (cyc < target) tick1();
   endtask

   task automatic apb_wr(input logic [4:0] ad, input logic [15:0] wd);
      psel = 1; penable = 0; pwrite = 1; paddr = ad; pwdata = wd;
      tick1(); penable = 1;
      tick1(); psel = 0; penable = 0; pwrite = 0;
   endtask

   task automatic apb_rd(input logic [4:0] ad, output logic [15:0] rd, output logic er);
      psel = 1; penable = 0; pwrite = 0; paddr = ad;
      tick1(); penable = 1; #1; rd = prdata; er = pslverr;
      tick1(); psel = 0; penable = 0;
   endtask

   task automatic rd_check(input string tag, input logic [4:0] ad, input logic [15:0] exp);
      logic [15:0] v;
      logic        e;
      apb_rd(ad, v, e);
      check(tag, v, exp);
   endtask

   task automatic tx_wait_start(output int unsigned ts);
      bit ok = 0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         tick1();
         if (tx === 1'b0) ok = 1;
      end
      check("tx_start_seen", ok, 1);
      ts = cyc;
   endtask

   task automatic tx_check_bits(input string tag, input int unsigned ts, input logic [7:0] v,
                                input bit pe, input bit po);
      logic [10:0] exp, got;
      int n;
      n   = pe ? 11 : 10;
      exp = pe ? {1'b1, par_bit(v, po), v, 1'b0} : {2'b01, v, 1'b0};
      got = '0;
      for (int k = 0; k < n; k++) begin
         wait_until(ts + BIT/2 + BIT*k);
         got[k] = tx;
      end
      check(tag, got, exp);
   endtask

   task automatic rx_send(input logic [7:0] v, input bit pe, input bit po,
                          input bit bad_par, input bit bad_stop);
      logic [10:0] f;
      logic p;
      int n;
      p = par_bit(v, po) ^ bad_par;
      f = pe ? {!bad_stop, p, v, 1'b0} : {1'b0, !bad_stop, v, 1'b0};
      n = pe ? 11 : 10;
      for (int k = 0; k < n; k++) begin
         rx = f[k];
         repeat (BIT) @(posedge clk);
      end
      #1 rx = 1'b1;
      repeat (8) tick1();
      if (rxq.size() < 8) rxq.push_back(v);
      else                e_ovf = 1;
      if (bad_stop)       e_frm = 1;
      if (pe && bad_par)  e_par = 1;
   endtask

   initial begin
      #2 rst_n = 1'b0;
      repeat (3) tick1();
      check("rst_tx", tx, 1);
      check("rst_prdata", prdata, 0);
      check("rst_pslverr", pslverr, 0);
      check("rst_txrdy", txrdy, 1);
      check("rst_rxrdy", rxrdy, 0);
      check("rst_irq", irq, 0);
      rst_n = 1'b1;
      tick1();
      rd_check("rst_status", A_STAT, exp_status(0, 0));
      rd_check("rst_baud", A_BAUD, 16'd26);
      rd_check("rst_ctrl", A_CTRL, 16'h0000);

      // TX-empty interrupt source, one cycle after CTRL takes effect
      apb_wr(A_CTRL, 16'h0008);
      tick1();
      check("irq_txempty_on", irq, 1);
      apb_wr(A_CTRL, 16'h0000);
      tick1();
      check("irq_txempty_off", irq, 0);
      apb_wr(A_CTRL, 16'h003F);
`ifdef UART_LOOPBACK_EN
      rd_check("ctrl_mask", A_CTRL, 16'h003F);
`else
      rd_check("ctrl_mask", A_CTRL, 16'h001F);
`endif
      apb_wr(A_CTRL, 16'h0000);

      // TX framing
      apb_wr(A_BAUD, 16'd3);
      rd_check("baud_rb", A_BAUD, 16'd3);
      apb_wr(A_DATA, 16'h0055);
      tx_wait_start(t0);
      check("tx1_txrdy", txrdy, 1);
      tx_check_bits("tx_frame_55", t0, 8'h55, 0, 0);
      d = 8'($urandom);
      apb_wr(A_DATA, {8'h00, d});
      tx_wait_start(t0);
      tx_check_bits("tx_frame_rand", t0, d, 0, 0);
      apb_wr(A_CTRL, 16'h0003);
      d = 8'($urandom);
      apb_wr(A_DATA, {8'h00, d});
      tx_wait_start(t0);
      tx_check_bits("tx_frame_oddpar", t0, d, 1, 1);
      repeat (2*BIT) tick1();
      rd_check("tx_idle_status", A_STAT, exp_status(0, 0));

      // RX with odd parity
      d = 8'hA3;
      rx_send(d, 1, 1, 0, 0);
      check("rx_rxrdy", rxrdy, 1);
      rd_check("rx_data_a3", A_DATA, {8'h00, rxq.pop_front()});
      rd_check("rx_status", A_STAT, exp_status(0, 0));
      check("rx_rxrdy_clr", rxrdy, 0);
      apb_rd(A_DATA, rdata, err);
      check("rx_empty_read", rdata, 0);
      check("rx_empty_err", err, 0);
      d = 8'($urandom);
      rx_send(d, 1, 1, 1, 0);
      rd_check("rx_parerr_status", A_STAT, exp_status(0, 1));
      rd_check("rx_parerr_data", A_DATA, {8'h00, rxq.pop_front()});
      apb_wr(A_STAT, 16'h0020);
      e_par = 0;
      rd_check("rx_parerr_w1c", A_STAT, exp_status(0, 0));
      apb_wr(A_CTRL, 16'h0001);
      d = 8'($urandom);
      rx_send(d, 1, 0, 0, 0);
      rd_check("rx_evenpar_data", A_DATA, {8'h00, rxq.pop_front()});
      rd_check("rx_evenpar_status", A_STAT, exp_status(0, 0));

      // RX overflow, IE_RX interrupt
      apb_wr(A_CTRL, 16'h0004);
      check("ovf_irq_pre", irq, 0);
      for (int i = 0; i < 9; i++) rx_send(8'($urandom), 0, 0, 0, 0);
      check("ovf_irq", irq, 1);
      rd_check("ovf_status", A_STAT, exp_status(0, 8));
      for (int i = 0; i < 8; i++) begin
         apb_rd(A_DATA, rdata, err);
         check($sformatf("ovf_data%0d", i), rdata, {8'h00, rxq.pop_front()});
      end
      check("ovf_rxrdy_clr", rxrdy, 0);
      tick1();
      check("ovf_irq_clr", irq, 0);
      apb_wr(A_STAT, 16'h0008);
      e_ovf = 0;
      rd_check("ovf_w1c", A_STAT, exp_status(0, 0));

      // Framing error with IE_ERR
      apb_wr(A_CTRL, 16'h0010);
      tick1();
      check("frm_irq_pre", irq, 0);
      d = 8'($urandom);
      rx_send(d, 0, 0, 0, 1);
      check("frm_irq", irq, 1);
      rd_check("frm_status", A_STAT, exp_status(0, 1));
      rd_check("frm_data", A_DATA, {8'h00, rxq.pop_front()});
      apb_wr(A_STAT, 16'h0010);
      e_frm = 0;
      tick1();
      check("frm_irq_clr", irq, 0);
      apb_wr(A_CTRL, 16'h0000);

      // TX overflow and back-to-back frames
      a = 8'($urandom);
      apb_wr(A_DATA, {8'h00, a});
      tx_wait_start(t0);
      for (int i = 0; i < 9; i++) begin
         d = 8'($urandom);
         apb_wr(A_DATA, {8'h00, d});
         if (i < 8) txb.push_back(d);
         else       e_txovf = 1;
      end
      check("txovf_txrdy", txrdy, 0);
      rd_check("txovf_status", A_STAT, exp_status(8, 0));
      tx_check_bits("b2b_frame_first", t0, a, 0, 0);
      for (int i = 0; i < 8; i++) begin
         tx_wait_start(t1);
         check($sformatf("b2b_gap%0d", i), t1 - t0, 10*BIT);
         if (i == 0) check("txovf_txrdy_after_pop", txrdy, 1);
         tx_check_bits($sformatf("b2b_frame%0d", i), t1, txb.pop_front(), 0, 0);
         t0 = t1;
      end
      repeat (2*BIT) tick1();
      apb_wr(A_STAT, 16'h0040);
      e_txovf = 0;
      rd_check("txovf_w1c", A_STAT, exp_status(0, 0));

      // Unmapped address
      apb_rd(5'h10, rdata, err);
      check("unmap_prdata", rdata, 0);
      check("unmap_pslverr", err, 1);
      apb_rd(A_CTRL, rdata, err);
      check("map_pslverr", err, 0);
      apb_wr(5'h10, 16'hFFFF);
      apb_wr(5'h1C, 16'hFFFF);
      rd_check("unmap_ctrl", A_CTRL, 16'h0000);
      rd_check("unmap_baud", A_BAUD, 16'd3);
      rd_check("unmap_status", A_STAT, exp_status(0, 0));

      // Reset mid-frame
      apb_wr(A_DATA, 16'h00F0);
      apb_wr(A_DATA, 16'h000F);
      tx_wait_start(t0);
      repeat (10) tick1();
      check("midrst_tx_low", tx, 0);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_tx", tx, 1);
      check("midrst_txrdy", txrdy, 1);
      check("midrst_rxrdy", rxrdy, 0);
      tick1();
      rst_n = 1'b1;
      tick1();
      rd_check("midrst_status", A_STAT, exp_status(0, 0));
      rd_check("midrst_baud", A_BAUD, 16'd26);
      zeros = 0;
      for (int i = 0; i < 800; i++) begin
         tick1();
         if (tx !== 1'b1) zeros++;
      end
      check("midrst_tx_quiet", zeros, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
